// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : md_sequencer
// Purpose  : Multiply/divide issue and latency controller that owns HI/LO.
//            The result is computed at issue, held for a fixed latency and
//            then committed to HI/LO.
//            Optional MD_CANCEL_EN adds a cancel input for E-stage flushes.
// Revision : 1.0  initial release
// ============================================================================
module md_sequencer #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        d_md_use,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        start,
    output logic        busy,
    output logic        stall
);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    localparam logic [3:0] c_MULT_CNT = 4'(MULT_LAT - 1);
    localparam logic [3:0] c_DIV_CNT  = 4'(DIV_LAT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_skip;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;

    logic        w_cancel;
    logic        w_is_md;
    logic        w_is_div;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic [31:0] w_divisor;
    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic [31:0] w_squot;
    logic [31:0] w_srem;
    logic [31:0] w_uquot;
    logic [31:0] w_urem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

`ifdef MD_CANCEL_EN
    assign w_cancel = cancel;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_is_md    = (md_op >= c_OP_MULT) && (md_op <= c_OP_DIVU);
    assign w_is_div   = (md_op == c_OP_DIV) || (md_op == c_OP_DIVU);
    assign w_div_zero = (op_b == 32'd0);
    assign w_div_ovf  = (md_op == c_OP_DIV) && (op_a == 32'h8000_0000) &&
                        (op_b == 32'hFFFF_FFFF);

    // Dividing by 1 keeps the divider defined for /0 (result discarded) and
    // yields exactly quotient=dividend, remainder=0 for the signed overflow.
    assign w_divisor = (w_div_zero || w_div_ovf) ? 32'd1 : op_b;

    assign w_smul  = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    assign w_umul  = {32'd0, op_a} * {32'd0, op_b};
    assign w_squot = $signed(op_a) / $signed(w_divisor);
    assign w_srem  = $signed(op_a) % $signed(w_divisor);
    assign w_uquot = op_a / w_divisor;
    assign w_urem  = op_a % w_divisor;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (md_op)
            c_OP_MULT: begin
                w_res_hi = w_smul[63:32];
                w_res_lo = w_smul[31:0];
            end
            c_OP_MULTU: begin
                w_res_hi = w_umul[63:32];
                w_res_lo = w_umul[31:0];
            end
            c_OP_DIV: begin
                w_res_hi = w_srem;
                w_res_lo = w_squot;
            end
            c_OP_DIVU: begin
                w_res_hi = w_urem;
                w_res_lo = w_uquot;
            end
            default: begin
                w_res_hi = 32'd0;
                w_res_lo = 32'd0;
            end
        endcase
    end

    // Gated by reset so nothing is reported to the hazard unit while held.
    assign start = reset && (r_state == ST_IDLE) && w_is_md && !w_cancel;
    assign stall = d_md_use && (start || r_busy);
    assign busy  = r_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_pend_skip <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_cancel) begin
                        if (w_is_md) begin
                            r_pend_hi   <= w_res_hi;
                            r_pend_lo   <= w_res_lo;
                            r_pend_skip <= w_is_div && w_div_zero;
                            r_cnt       <= w_is_div ? c_DIV_CNT : c_MULT_CNT;
                            r_state     <= ST_RUN;
                            r_busy      <= 1'b1;
                        end else if (md_op == c_OP_MTHI) begin
                            r_hi <= op_a;
                        end else if (md_op == c_OP_MTLO) begin
                            r_lo <= op_a;
                        end
                    end
                end
                ST_RUN: begin
                    // Any md_op seen here is ignored; the stall keeps it away.
                    if (w_cancel) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_pend_skip) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sequencer
// Purpose  : Directed self-checking bench for md_sequencer with a scoreboard
//            of expected HI/LO commits.
// Revision : 1.0  initial release
// ============================================================================
module tb_md_sequencer;

    localparam int c_MULT_LAT = 5;
    localparam int c_DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic [2:0]  md_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        d_md_use;
`ifdef MD_CANCEL_EN
    logic        cancel;
`endif
    logic [31:0] hi;
    logic [31:0] lo;
    logic        start;
    logic        busy;
    logic        stall;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_sequencer #(
        .MULT_LAT (c_MULT_LAT),
        .DIV_LAT  (c_DIV_LAT)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .op_a     (op_a),
        .op_b     (op_b),
        .d_md_use (d_md_use),
`ifdef MD_CANCEL_EN
        .cancel   (cancel),
`endif
        .hi       (hi),
        .lo       (lo),
        .start    (start),
        .busy     (busy),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle, walk the busy window, then compare
    // the commit against the scoreboard. intrude>0 presents a mult in that
    // busy cycle, which must be ignored.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eh, input logic [31:0] el,
                          input logic use_d, input int intrude);
        logic [63:0] e;
        md_op = op; op_a = a; op_b = b; d_md_use = use_d;
        #1;
        check("start_issue", {31'd0, start}, 32'd1);
        check("busy_issue",  {31'd0, busy},  32'd0);
        check("stall_issue", {31'd0, stall}, {31'd0, use_d});
        exp_q.push_back({eh, el});
        for (int i = 1; i <= lat; i++) begin
            tick();
            md_op = (i == intrude) ? 3'd1 : 3'd0;
            op_a  = $urandom;
            op_b  = $urandom;
            #1;
            check("start_run", {31'd0, start}, 32'd0);
            check("busy_run",  {31'd0, busy},  32'd1);
            check("stall_run", {31'd0, stall}, {31'd0, use_d});
            check("hi_hold",   hi, m_hi);
            check("lo_hold",   lo, m_lo);
        end
        tick();
        md_op = 3'd0;
        #1;
        check("busy_done",  {31'd0, busy},  32'd0);
        check("stall_done", {31'd0, stall}, 32'd0);
        e = exp_q.pop_front();
        check("hi_commit", hi, e[63:32]);
        check("lo_commit", lo, e[31:0]);
        m_hi = e[63:32];
        m_lo = e[31:0];
        d_md_use = 1'b0;
    endtask

    initial begin
        reset = 1'b0; md_op = 3'd1; op_a = 32'd3; op_b = 32'd4; d_md_use = 1'b1;
`ifdef MD_CANCEL_EN
        cancel = 1'b0;
`endif
        m_hi = 32'd0; m_lo = 32'd0;
        tick(); tick();
        #1;
        check("rst_hi",    hi, 32'd0);
        check("rst_lo",    lo, 32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b1; md_op = 3'd0; d_md_use = 1'b0;
        tick();

        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, c_MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, c_MULT_LAT, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, c_DIV_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        run_op(3'd4, 32'h0000_0007, 32'h0000_0000, c_DIV_LAT,  m_hi, m_lo, 1'b0, 0);
        run_op(3'd3, 32'h0000_0064, 32'h0000_0007, c_DIV_LAT,  32'h0000_0002, 32'h0000_000E, 1'b1, 3);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, c_DIV_LAT,  32'h0000_0000, 32'h8000_0000, 1'b0, 0);
        run_op(3'd1, 32'h0001_0000, 32'hFFFF_0000, c_MULT_LAT, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0);

        // mthi then mtlo back to back
        md_op = 3'd5; op_a = 32'h1234_5678;
        #1;
        check("mthi_start", {31'd0, start}, 32'd0);
        tick();
        md_op = 3'd6; op_a = 32'h9ABC_DEF0;
        #1;
        check("mthi_hi",   hi, 32'h1234_5678);
        check("mthi_lo",   lo, m_lo);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        tick();
        md_op = 3'd0;
        #1;
        check("mtlo_lo",   lo, 32'h9ABC_DEF0);
        check("mtlo_hi",   hi, 32'h1234_5678);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

`ifdef MD_CANCEL_EN
        // Cancel during busy cycle 2 discards the result
        md_op = 3'd1; op_a = 32'd6; op_b = 32'd7;
        #1;
        check("cxl_start", {31'd0, start}, 32'd1);
        tick(); md_op = 3'd0;
        tick(); cancel = 1'b1;
        #1;
        check("cxl_busy2", {31'd0, busy}, 32'd1);
        tick(); cancel = 1'b0;
        #1;
        check("cxl_busy_drop", {31'd0, busy}, 32'd0);
        check("cxl_hi", hi, m_hi);
        check("cxl_lo", lo, m_lo);
        tick();
        run_op(3'd2, 32'd6, 32'd7, c_MULT_LAT, 32'd0, 32'd42, 1'b0, 0);
`endif

        // Reset in busy cycle 3 of a mult drops everything immediately
        md_op = 3'd1; op_a = 32'd9; op_b = 32'd9;
        #1;
        check("rmid_start", {31'd0, start}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            md_op = 3'd0;
        end
        #1;
        check("rmid_busy3", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("rmid_busy", {31'd0, busy}, 32'd0);
        check("rmid_hi", hi, 32'd0);
        check("rmid_lo", lo, 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < c_MULT_LAT + 2; i++) begin
            tick();
            #1;
            check("rpost_busy", {31'd0, busy}, 32'd0);
            check("rpost_hi", hi, 32'd0);
            check("rpost_lo", lo, 32'd0);
        end

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
